// File: rtl/fu_issue_tracker_pkg.sv
// Shared issue-side types: RS issue packet, FU empty flags, mult slot states,
// the common NOP issue packet and a saturating counter helper.
package fu_issue_tracker_pkg;

    localparam int unsigned NUM_ALU      = 3;
    localparam int unsigned NUM_MULT     = 2;
    localparam int unsigned NUM_IS_PORTS = 3;
    localparam int unsigned TAG_W        = 6;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned STAT_W       = 32;

    typedef enum logic [2:0] {
        FUNC_NOP = 3'd0,
        FUNC_ALU = 3'd1,
        FUNC_MUL = 3'd2,
        FUNC_MEM = 3'd3,
        FUNC_BR  = 3'd4
    } FUNC_UNIT;

    typedef struct packed {
        logic                 valid;
        logic                 illegal;
        FUNC_UNIT             func_unit;
        logic [TAG_W-1:0]     tag;
        logic [REG_IDX_W-1:0] dest_reg_idx;
        logic [XLEN-1:0]      rs1_value;
        logic [XLEN-1:0]      rs2_value;
    } RS_IS_PACKET;

    typedef struct packed {
        logic [NUM_ALU-1:0]  ALU_empty;
        logic [NUM_MULT-1:0] MULT_empty;
    } FU_EMPTY_PACKET;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } MULT_SLOT_STATE;

    localparam RS_IS_PACKET NOP_IS_PACKET = '{
        valid:        1'b0,
        illegal:      1'b1,
        func_unit:    FUNC_NOP,
        tag:          '0,
        dest_reg_idx: '0,
        rs1_value:    '0,
        rs2_value:    '0
    };

    // Add a small per-cycle increment, sticking at all ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [1:0]        b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + (STAT_W+1)'(b);
        return s[STAT_W] ? '1 : s[STAT_W-1:0];
    endfunction

endpackage

// File: rtl/fu_issue_tracker_if.sv
// RS issue / CDB-ack / FU status bundle; master is the RS+CDB side,
// slave is the issue tracker.
interface fu_issue_tracker_if;
    import fu_issue_tracker_pkg::*;

    logic                             squash_flag;
    RS_IS_PACKET [NUM_IS_PORTS-1:0]   is_packet_in;
    logic        [NUM_ALU-1:0]        alu_ack;
    logic        [NUM_MULT-1:0]       mult_ack;
    FU_EMPTY_PACKET                   fu_empty_packet;
    RS_IS_PACKET [NUM_ALU-1:0]        alu_packet_out;
    RS_IS_PACKET [NUM_MULT-1:0]       mult_packet_out;
    logic        [NUM_MULT-1:0]       mult_done;
    logic                             overflow_err;

    modport master (
        output squash_flag, is_packet_in, alu_ack, mult_ack,
        input  fu_empty_packet, alu_packet_out, mult_packet_out, mult_done, overflow_err
    );

    modport slave (
        input  squash_flag, is_packet_in, alu_ack, mult_ack,
        output fu_empty_packet, alu_packet_out, mult_packet_out, mult_done, overflow_err
    );

endinterface

// File: rtl/fu_issue_tracker_mult_slot.sv
// One multi-cycle multiplier slot: IDLE -> BUSY (MULT_LAT-1 countdown) -> DONE -> IDLE on ack.
module mult_slot
    import fu_issue_tracker_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        alloc,
    input  logic        ack,
    input  RS_IS_PACKET pkt_i,
    output RS_IS_PACKET pkt_o,
    output logic        idle_o,
    output logic        done_o
);

    localparam int unsigned CNT_W = $clog2(MULT_LAT);

    MULT_SLOT_STATE   state_q;
    logic [CNT_W-1:0] cnt_q;
    RS_IS_PACKET      pkt_q;
    logic             idle_q;
    logic             done_q;

    // Slot FSM; DONE is entered on the cycle the countdown would reach zero.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            pkt_q   <= NOP_IS_PACKET;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (alloc) begin
                        state_q <= MS_BUSY;
                        cnt_q   <= CNT_W'(MULT_LAT - 1);
                        pkt_q   <= pkt_i;
                        idle_q  <= 1'b0;
                    end
                end
                MS_BUSY: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= MS_DONE;
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                MS_DONE: begin
                    if (ack) begin
                        state_q <= MS_IDLE;
                        pkt_q   <= NOP_IS_PACKET;
                        idle_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= MS_IDLE;
                    cnt_q   <= '0;
                    pkt_q   <= NOP_IS_PACKET;
                    idle_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pkt_o  = pkt_q;
    assign idle_o = idle_q;
    assign done_o = done_q;

endmodule

// File: rtl/fu_issue_tracker.sv
// Issue tracker: steers RS issue packets onto ALU lanes and mult slots and
// reports registered empty flags. Optional stats counters: FU_ISSUE_STATS_EN.
module fu_issue_tracker
    import fu_issue_tracker_pkg::*;
#(
    parameter int unsigned MULT_LAT   = 4,
    parameter int unsigned ALU_LANES  = 3,
    parameter int unsigned MULT_LANES = 2
) (
    input  logic               clock,
    input  logic               reset,
`ifdef FU_ISSUE_STATS_EN
    output logic [STAT_W-1:0]  alu_issue_cnt,
    output logic [STAT_W-1:0]  mult_issue_cnt,
    output logic [STAT_W-1:0]  drop_cnt,
`endif
    fu_issue_tracker_if.slave  bus
);

    logic [ALU_LANES-1:0]  alu_free_q, alu_free_d;
    RS_IS_PACKET           alu_pkt_q [ALU_LANES];
    RS_IS_PACKET           alu_pkt_d [ALU_LANES];
    logic                  overflow_q, overflow_d;

    logic [ALU_LANES-1:0]  alu_alloc_c;
    RS_IS_PACKET           alu_new_c [ALU_LANES];
    logic [MULT_LANES-1:0] mult_alloc_c;
    RS_IS_PACKET           mult_new_c [MULT_LANES];
    logic                  drop_c;
    logic                  placed_c;

    logic [MULT_LANES-1:0] mult_idle_w;
    logic [MULT_LANES-1:0] mult_done_w;
    RS_IS_PACKET           mult_pkt_w [MULT_LANES];

`ifdef FU_ISSUE_STATS_EN
    logic [1:0]            alu_n_c, mult_n_c, drop_n_c;
    logic [STAT_W-1:0]     alu_cnt_q, mult_cnt_q, drop_cnt_q;
`endif

    // Port-priority allocation against start-of-cycle free state only.
    always_comb begin
        alu_alloc_c  = '0;
        mult_alloc_c = '0;
        drop_c       = 1'b0;
        placed_c     = 1'b0;
        for (int l = 0; l < ALU_LANES; l++) alu_new_c[l] = NOP_IS_PACKET;
        for (int m = 0; m < MULT_LANES; m++) mult_new_c[m] = NOP_IS_PACKET;
`ifdef FU_ISSUE_STATS_EN
        alu_n_c  = 2'd0;
        mult_n_c = 2'd0;
        drop_n_c = 2'd0;
`endif
        for (int p = 0; p < NUM_IS_PORTS; p++) begin
            placed_c = 1'b0;
            if (bus.is_packet_in[p].valid && bus.is_packet_in[p].func_unit == FUNC_ALU) begin
                for (int l = 0; l < ALU_LANES; l++) begin
                    if (!placed_c && alu_free_q[l] && !alu_alloc_c[l]) begin
                        alu_alloc_c[l] = 1'b1;
                        alu_new_c[l]   = bus.is_packet_in[p];
                        placed_c       = 1'b1;
                    end
                end
                if (!placed_c) drop_c = 1'b1;
`ifdef FU_ISSUE_STATS_EN
                if (placed_c) alu_n_c = alu_n_c + 2'd1;
                else          drop_n_c = drop_n_c + 2'd1;
`endif
            end else if (bus.is_packet_in[p].valid && bus.is_packet_in[p].func_unit == FUNC_MUL) begin
                for (int m = 0; m < MULT_LANES; m++) begin
                    if (!placed_c && mult_idle_w[m] && !mult_alloc_c[m]) begin
                        mult_alloc_c[m] = 1'b1;
                        mult_new_c[m]   = bus.is_packet_in[p];
                        placed_c        = 1'b1;
                    end
                end
                if (!placed_c) drop_c = 1'b1;
`ifdef FU_ISSUE_STATS_EN
                if (placed_c) mult_n_c = mult_n_c + 2'd1;
                else          drop_n_c = drop_n_c + 2'd1;
`endif
            end
        end
    end

    // ALU lane next state; squash overrides acks and new allocations.
    always_comb begin
        alu_free_d = alu_free_q;
        alu_pkt_d  = alu_pkt_q;
        overflow_d = overflow_q;
        if (bus.squash_flag) begin
            alu_free_d = '1;
            for (int l = 0; l < ALU_LANES; l++) alu_pkt_d[l] = NOP_IS_PACKET;
        end else begin
            for (int l = 0; l < ALU_LANES; l++) begin
                if (!alu_free_q[l] && bus.alu_ack[l]) begin
                    alu_free_d[l] = 1'b1;
                    alu_pkt_d[l]  = NOP_IS_PACKET;
                end else if (alu_alloc_c[l]) begin
                    alu_free_d[l] = 1'b0;
                    alu_pkt_d[l]  = alu_new_c[l];
                end
            end
            if (drop_c) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_free_q <= '1;
            for (int l = 0; l < ALU_LANES; l++) alu_pkt_q[l] <= NOP_IS_PACKET;
            overflow_q <= 1'b0;
        end else begin
            alu_free_q <= alu_free_d;
            alu_pkt_q  <= alu_pkt_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar m = 0; m < MULT_LANES; m++) begin : g_mult
        mult_slot #(
            .MULT_LAT (MULT_LAT)
        ) u_mult_slot (
            .clock  (clock),
            .reset  (reset),
            .flush  (bus.squash_flag),
            .alloc  (mult_alloc_c[m]),
            .ack    (bus.mult_ack[m]),
            .pkt_i  (mult_new_c[m]),
            .pkt_o  (mult_pkt_w[m]),
            .idle_o (mult_idle_w[m]),
            .done_o (mult_done_w[m])
        );
        assign bus.mult_packet_out[m] = mult_pkt_w[m];
    end

    for (genvar l = 0; l < ALU_LANES; l++) begin : g_alu_out
        assign bus.alu_packet_out[l] = alu_pkt_q[l];
    end

    assign bus.fu_empty_packet = '{ALU_empty: alu_free_q, MULT_empty: mult_idle_w};
    assign bus.mult_done       = mult_done_w;
    assign bus.overflow_err    = overflow_q;

`ifdef FU_ISSUE_STATS_EN
    // Activity counters survive squash; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_cnt_q  <= '0;
            mult_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else if (!bus.squash_flag) begin
            alu_cnt_q  <= sat_add(alu_cnt_q, alu_n_c);
            mult_cnt_q <= sat_add(mult_cnt_q, mult_n_c);
            drop_cnt_q <= sat_add(drop_cnt_q, drop_n_c);
        end
    end

    assign alu_issue_cnt  = alu_cnt_q;
    assign mult_issue_cnt = mult_cnt_q;
    assign drop_cnt       = drop_cnt_q;
`endif

endmodule
